blk_frame_sequencer: RTL and testbench
======================================

Name: blk_frame_sequencer

Overview:
- Per-frame controller for the falling-block datapath: 10 coordinate registers, the random spawn generator and the 20x20 tile drawer.
- On each frame tick it runs four phases in order: erase every block, step all blocks one position in the latched direction, periodically capture a random coordinate into the next slot, then redraw every block.
- It produces the one-hot ld_blk strobes, the increment and capture pulses, the draw enable, and the tile scan counters consumed by the pixel path.

Parameters:
- NUM_BLK, 10, number of block slots; blk_sel range is 0..NUM_BLK-1.
- TILE, 20, tile edge in pixels; pix_x/pix_y range is 0..TILE-1.
- SPAWN_EVERY, 4, a spawn occurs once every SPAWN_EVERY frames.
- SETTLE, 2, cycles between the capture pulse and ld_blk; covers the reg_rand plus filter pipeline.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- run  in  1  level; high permits frames to start.
- frame_tick  in  1  one-cycle pulse from the delay counter.
- dir  in  2  movement direction (00 down, 01 left, 10 up, 11 right).
- dir_out  out  2  direction latched for the current frame.
- capture  out  1  one-cycle pulse to the random register stage.
- ld_blk  out  NUM_BLK  one-hot load strobe, one cycle wide.
- increment  out  1  one-cycle step pulse to all coordinate counters.
- draw_en  out  1  high during every scan cycle.
- erase  out  1  high during the erase scan; the pixel path forces colour to 0.
- blk_sel  out  4  block being scanned.
- pix_x  out  5  column offset within the tile.
- pix_y  out  5  row offset within the tile.
- busy  out  1  high in any state other than IDLE and WAIT_TICK.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- overrun  out  1  sticky flag: a frame_tick arrived while busy.

Behaviour:
- All outputs are registered.
- Reset (reset=0 at a clock edge): on the next edge, state=IDLE and every output is 0. The internal slot pointer and spawn counter are cleared. Reset takes precedence over everything, including mid-frame operation.
- IDLE: if run=1, go to WAIT_TICK.
- WAIT_TICK:
  - If run=0, go to IDLE.
  - Else if frame_tick=1: latch dir into dir_out and go to ERASE.
  - Spawn decision for the frame: spawn_now = (spawn_cnt==0); then spawn_cnt = (spawn_cnt+1) mod SPAWN_EVERY. The first frame after reset therefore spawns.
- ERASE: draw_en=1, erase=1. Scans NUM_BLK*TILE*TILE cycles (4000 at defaults).
- Scan order (ERASE and DRAW):
  - pix_x increments every cycle and wraps TILE-1 -> 0.
  - When pix_x wraps, pix_y increments; it wraps TILE-1 -> 0.
  - When both wrap, blk_sel increments.
  - The phase exits after blk_sel=NUM_BLK-1, pix_y=TILE-1, pix_x=TILE-1.
  - blk_sel, pix_x and pix_y are 0 outside scan states.
- MOVE: 1 cycle with increment=1. Next state is CAP if spawn_now, else DRAW.
- CAP: 1 cycle with capture=1. Next state is SETTLE.
- SETTLE: SETTLE cycles with all strobes 0. Next state is LOAD.
- LOAD: 1 cycle with ld_blk[slot]=1. Then slot = (slot==NUM_BLK-1) ? 0 : slot+1. Next state is DRAW.
- DRAW: same scan as ERASE with erase=0, draw_en=1.
- DONE: 1 cycle with frame_done=1. Next state is WAIT_TICK; run is re-checked there.
- Frame length, counted from the first ERASE cycle: 8002 cycles without a spawn, 8006 with a spawn (defaults).
- frame_tick while busy or in DONE: the tick is dropped, overrun<=1, and overrun holds until reset. No frame is queued.
- frame_tick in IDLE: ignored; overrun is not set.
- dir changes mid-frame are ignored until the next WAIT_TICK latch.
- run falling mid-frame: the current frame completes, then WAIT_TICK goes to IDLE.
- At most one ld_blk bit is high at any time. increment, capture and ld_blk are never high in the same cycle.

Test Plan:
1. reset low 2 cycles, then run=1 and a frame_tick pulse, with ERASE's first cycle counted as cycle 1:
   - Cycle 1: erase=1, blk_sel=0, pix 0/0.
   - Cycle 21: pix_y=1.
   - Cycle 401: blk_sel=1.
   - Cycle 4001: increment=1.
   - Cycle 4002: capture=1.
   - Cycle 4005: ld_blk=10'b0000000001.
   - Cycles 4006-8005: draw_en=1, erase=0.
   - Cycle 8006: frame_done=1.
2. Frames 2-4: no capture and no ld_blk; frame_done at cycle 8002. Frame 5: ld_blk=10'b0000000010.
3. Run 41 frames: the 10th spawn loads slot 9 (bit 9); the 11th spawn loads slot 0 again.
4. dir=11 at the tick, then dir=01 during ERASE: dir_out stays 11 for the whole frame and the next frame latches 01.
5. frame_tick at cycle 5000 (DRAW): overrun=1 from the next edge and stays 1; only one frame_done is produced.
6. reset=0 at cycle 6000: next edge busy=0, draw_en=0, overrun=0, state IDLE. After release with run=1 and a tick, the next spawn goes to slot 0. With run=0 after a frame completes, the tick is ignored and busy stays 0.

Source files
------------

// File: rtl/blk_frame_sequencer.sv
// Frame controller for the falling-block datapath: erase, move, optional spawn, redraw.
// Drives the coordinate load/step strobes, the random capture pulse and the tile scan counters.
//
// state       | meaning
// S_IDLE      | stopped, waiting for run
// S_WAIT_TICK | armed; latches dir and spawn decision on frame_tick
// S_ERASE     | scan all tiles with colour forced to 0
// S_MOVE      | one-cycle increment pulse to every coordinate counter
// S_CAP       | one-cycle capture pulse to the random register stage
// S_SETTLE    | wait for the random/filter pipeline to settle
// S_LOAD      | one-hot load of the captured coordinate into the current slot
// S_DRAW      | scan all tiles with real colour
// S_DONE      | one-cycle frame_done pulse
module blk_frame_sequencer #(
    parameter int NUM_BLK     = 10,
    parameter int TILE        = 20,
    parameter int SPAWN_EVERY = 4,
    parameter int SETTLE      = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               frame_tick,
    input  logic [1:0]         dir,
    output logic [1:0]         dir_out,
    output logic               capture,
    output logic [NUM_BLK-1:0] ld_blk,
    output logic               increment,
    output logic               draw_en,
    output logic               erase,
    output logic [3:0]         blk_sel,
    output logic [4:0]         pix_x,
    output logic [4:0]         pix_y,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);

    localparam int SPW = (SPAWN_EVERY > 1) ? $clog2(SPAWN_EVERY) : 1;
    localparam int STW = $clog2(SETTLE) + 1;
    localparam logic [3:0]     LAST_BLK   = 4'(NUM_BLK - 1);
    localparam logic [4:0]     LAST_PIX   = 5'(TILE - 1);
    localparam logic [SPW-1:0] LAST_SPAWN = SPW'(SPAWN_EVERY - 1);
    localparam logic [STW-1:0] SETTLE_TC  = STW'(SETTLE - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_TICK, S_ERASE, S_MOVE, S_CAP, S_SETTLE, S_LOAD, S_DRAW, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         dir_out_q, dir_out_d;
    logic [3:0]         slot_q, slot_d;
    logic [SPW-1:0]     spawn_cnt_q, spawn_cnt_d;
    logic               spawn_now_q, spawn_now_d;
    logic [STW-1:0]     settle_cnt_q, settle_cnt_d;
    logic [3:0]         blk_sel_q, blk_sel_d;
    logic [4:0]         pix_x_q, pix_x_d;
    logic [4:0]         pix_y_q, pix_y_d;
    logic               capture_q, capture_d;
    logic [NUM_BLK-1:0] ld_blk_q, ld_blk_d;
    logic               increment_q, increment_d;
    logic               draw_en_q, draw_en_d;
    logic               erase_q, erase_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               overrun_q, overrun_d;

    logic       in_scan, scan_last, x_wrap, y_wrap;
    logic [3:0] blk_adv;
    logic [4:0] x_adv, y_adv;

    always_comb begin
        in_scan   = (state_q == S_ERASE) || (state_q == S_DRAW);
        x_wrap    = (pix_x_q == LAST_PIX);
        y_wrap    = (pix_y_q == LAST_PIX);
        scan_last = x_wrap && y_wrap && (blk_sel_q == LAST_BLK);
        x_adv     = x_wrap ? 5'd0 : pix_x_q + 5'd1;
        y_adv     = pix_y_q;
        blk_adv   = blk_sel_q;
        if (x_wrap) begin
            y_adv = y_wrap ? 5'd0 : pix_y_q + 5'd1;
        end
        if (x_wrap && y_wrap) begin
            blk_adv = (blk_sel_q == LAST_BLK) ? 4'd0 : blk_sel_q + 4'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_out_d    = dir_out_q;
        slot_d       = slot_q;
        spawn_cnt_d  = spawn_cnt_q;
        spawn_now_d  = spawn_now_q;
        settle_cnt_d = settle_cnt_q;
        // Ticks are only accepted in WAIT_TICK; anywhere busy they are dropped and flagged.
        overrun_d    = overrun_q || (frame_tick && (state_q != S_IDLE) && (state_q != S_WAIT_TICK));

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (frame_tick) begin
                    dir_out_d   = dir;
                    spawn_now_d = (spawn_cnt_q == '0);
                    spawn_cnt_d = (spawn_cnt_q == LAST_SPAWN) ? '0 : spawn_cnt_q + 1'b1;
                    state_d     = S_ERASE;
                end
            end
            S_ERASE: begin
                if (scan_last) state_d = S_MOVE;
            end
            S_MOVE: begin
                state_d = spawn_now_q ? S_CAP : S_DRAW;
            end
            S_CAP: begin
                settle_cnt_d = SETTLE_TC;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt_q == '0) state_d = S_LOAD;
                else                    settle_cnt_d = settle_cnt_q - 1'b1;
            end
            S_LOAD: begin
                slot_d  = (slot_q == LAST_BLK) ? 4'd0 : slot_q + 4'd1;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (scan_last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_WAIT_TICK;
            end
            default: state_d = S_IDLE;
        endcase

        // Counters keep stepping only while staying in the same scan phase; every phase
        // boundary lands them on zero, which is also their idle value.
        if (in_scan && (state_d == state_q)) begin
            pix_x_d   = x_adv;
            pix_y_d   = y_adv;
            blk_sel_d = blk_adv;
        end else begin
            pix_x_d   = 5'd0;
            pix_y_d   = 5'd0;
            blk_sel_d = 4'd0;
        end

        erase_d      = (state_d == S_ERASE);
        draw_en_d    = (state_d == S_ERASE) || (state_d == S_DRAW);
        increment_d  = (state_d == S_MOVE);
        capture_d    = (state_d == S_CAP);
        frame_done_d = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE) && (state_d != S_WAIT_TICK);
        ld_blk_d     = '0;
        if (state_d == S_LOAD) ld_blk_d[slot_q] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            dir_out_q    <= '0;
            slot_q       <= '0;
            spawn_cnt_q  <= '0;
            spawn_now_q  <= 1'b0;
            settle_cnt_q <= '0;
            blk_sel_q    <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            capture_q    <= 1'b0;
            ld_blk_q     <= '0;
            increment_q  <= 1'b0;
            draw_en_q    <= 1'b0;
            erase_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_out_q    <= dir_out_d;
            slot_q       <= slot_d;
            spawn_cnt_q  <= spawn_cnt_d;
            spawn_now_q  <= spawn_now_d;
            settle_cnt_q <= settle_cnt_d;
            blk_sel_q    <= blk_sel_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            capture_q    <= capture_d;
            ld_blk_q     <= ld_blk_d;
            increment_q  <= increment_d;
            draw_en_q    <= draw_en_d;
            erase_q      <= erase_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dir_out    = dir_out_q;
    assign capture    = capture_q;
    assign ld_blk     = ld_blk_q;
    assign increment  = increment_q;
    assign draw_en    = draw_en_q;
    assign erase      = erase_q;
    assign blk_sel    = blk_sel_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_blk_frame_sequencer.sv
// Bench for blk_frame_sequencer: default-size instance for frame timing, overrun and reset,
// plus a small-tile instance to walk the spawn slot pointer through its wrap.
module tb_blk_frame_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, run, frame_tick;
    logic [1:0] dir;
    logic [1:0] dir_out;
    logic       capture, increment, draw_en, erase, busy, frame_done, overrun;
    logic [9:0] ld_blk;
    logic [3:0] blk_sel;
    logic [4:0] pix_x, pix_y;

    blk_frame_sequencer dut (
        .clock(clock), .reset(reset), .run(run), .frame_tick(frame_tick), .dir(dir),
        .dir_out(dir_out), .capture(capture), .ld_blk(ld_blk), .increment(increment),
        .draw_en(draw_en), .erase(erase), .blk_sel(blk_sel), .pix_x(pix_x), .pix_y(pix_y),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    logic       s_reset, s_run, s_tick;
    logic [1:0] s_dir;
    logic [1:0] s_dir_out;
    logic       s_capture, s_increment, s_draw_en, s_erase, s_busy, s_frame_done, s_overrun;
    logic [9:0] s_ld_blk;
    logic [3:0] s_blk_sel;
    logic [4:0] s_pix_x, s_pix_y;

    blk_frame_sequencer #(.NUM_BLK(10), .TILE(4), .SPAWN_EVERY(4), .SETTLE(2)) dut_small (
        .clock(clock), .reset(s_reset), .run(s_run), .frame_tick(s_tick), .dir(s_dir),
        .dir_out(s_dir_out), .capture(s_capture), .ld_blk(s_ld_blk), .increment(s_increment),
        .draw_en(s_draw_en), .erase(s_erase), .blk_sel(s_blk_sel), .pix_x(s_pix_x),
        .pix_y(s_pix_y), .busy(s_busy), .frame_done(s_frame_done), .overrun(s_overrun)
    );

    int   n_chk = 0;
    int   n_bad = 0;
    logic ov_model = 1'b0;

    typedef struct {
        int          cyc;
        logic [29:0] exp;
    } vec_t;
    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // {erase, draw_en, increment, capture, frame_done, busy, ld_blk, blk_sel, pix_y, pix_x}
    function automatic logic [29:0] pack_main();
        return {erase, draw_en, increment, capture, frame_done, busy, ld_blk, blk_sel, pix_y, pix_x};
    endfunction

    function automatic vec_t mk(input int c, input logic er, input logic de, input logic inc,
                                input logic cap, input logic fd, input logic bz,
                                input logic [9:0] ld, input logic [3:0] b,
                                input logic [4:0] y, input logic [4:0] x);
        vec_t v;
        v.cyc = c;
        v.exp = {er, de, inc, cap, fd, bz, ld, b, y, x};
        return v;
    endfunction

    task automatic run_frame(input string tag, input logic exp_spawn, input logic [9:0] exp_ld,
                             input logic [1:0] dir_tick, input logic [1:0] dir_mid,
                             input int tick_at, input int run_off_at, input bit use_tbl);
        int c, vi, done_at, inc_at, n_inc, n_cap, n_ld, n_er, n_dr, n_fd;
        int scan_err, excl_err, dir_err, ov_err, busy_err, eb, ey, ex;
        logic [9:0] ld_seen;
        done_at = 0; inc_at = 0; n_inc = 0; n_cap = 0; n_ld = 0; n_er = 0; n_dr = 0; n_fd = 0;
        scan_err = 0; excl_err = 0; dir_err = 0; ov_err = 0; busy_err = 0;
        eb = 0; ey = 0; ex = 0; vi = 0; ld_seen = '0;
        dir = dir_tick;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        c = 1;
        while (done_at == 0 && c <= 8100) begin
            if (use_tbl && vi < 14 && vt[vi].cyc == c) begin
                check($sformatf("%s_vec_c%0d", tag, c), 32'(pack_main()), 32'(vt[vi].exp));
                vi++;
            end
            if (increment) begin n_inc++; inc_at = c; end
            if (capture) n_cap++;
            if (ld_blk != 10'd0) begin n_ld++; ld_seen |= ld_blk; end
            if (int'(increment) + int'(capture) + $countones(ld_blk) > 1) excl_err++;
            if (erase) n_er++;
            if (draw_en) begin
                n_dr++;
                if (int'(blk_sel) != eb || int'(pix_y) != ey || int'(pix_x) != ex) scan_err++;
                if (erase != (n_dr <= 4000)) scan_err++;
                ex++;
                if (ex == 20) begin
                    ex = 0; ey++;
                    if (ey == 20) begin ey = 0; eb = (eb == 9) ? 0 : eb + 1; end
                end
            end else if (blk_sel != 4'd0 || pix_x != 5'd0 || pix_y != 5'd0 || erase) begin
                scan_err++;
            end
            if (dir_out !== dir_tick) dir_err++;
            if (overrun !== ov_model) ov_err++;
            if (busy !== 1'b1) busy_err++;
            if (frame_done) begin n_fd++; done_at = c; end
            if (c == 1) dir = dir_mid;
            if (c == run_off_at) run = 1'b0;
            frame_tick = (c == tick_at);
            if (c == tick_at) ov_model = 1'b1;
            step();
            c++;
        end
        frame_tick = 1'b0;
        check({tag, "_frame_len"}, 32'(done_at), exp_spawn ? 32'd8006 : 32'd8002);
        check({tag, "_inc_cycle"}, 32'(inc_at), 32'd4001);
        check({tag, "_n_inc"}, 32'(n_inc), 32'd1);
        check({tag, "_n_cap"}, 32'(n_cap), 32'(exp_spawn));
        check({tag, "_n_ld"}, 32'(n_ld), 32'(exp_spawn));
        check({tag, "_ld_slot"}, 32'(ld_seen), 32'(exp_ld));
        check({tag, "_n_erase"}, 32'(n_er), 32'd4000);
        check({tag, "_n_draw_en"}, 32'(n_dr), 32'd8000);
        check({tag, "_n_frame_done"}, 32'(n_fd), 32'd1);
        check({tag, "_scan_err"}, 32'(scan_err), 32'd0);
        check({tag, "_strobe_excl_err"}, 32'(excl_err), 32'd0);
        check({tag, "_dir_err"}, 32'(dir_err), 32'd0);
        check({tag, "_overrun_err"}, 32'(ov_err), 32'd0);
        check({tag, "_busy_err"}, 32'(busy_err), 32'd0);
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
        check({tag, "_post_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        vt[0]  = mk(1,    1, 1, 0, 0, 0, 1, 10'd0, 4'd0, 5'd0,  5'd0);
        vt[1]  = mk(20,   1, 1, 0, 0, 0, 1, 10'd0, 4'd0, 5'd0,  5'd19);
        vt[2]  = mk(21,   1, 1, 0, 0, 0, 1, 10'd0, 4'd0, 5'd1,  5'd0);
        vt[3]  = mk(400,  1, 1, 0, 0, 0, 1, 10'd0, 4'd0, 5'd19, 5'd19);
        vt[4]  = mk(401,  1, 1, 0, 0, 0, 1, 10'd0, 4'd1, 5'd0,  5'd0);
        vt[5]  = mk(4000, 1, 1, 0, 0, 0, 1, 10'd0, 4'd9, 5'd19, 5'd19);
        vt[6]  = mk(4001, 0, 0, 1, 0, 0, 1, 10'd0, 4'd0, 5'd0,  5'd0);
        vt[7]  = mk(4002, 0, 0, 0, 1, 0, 1, 10'd0, 4'd0, 5'd0,  5'd0);
        vt[8]  = mk(4003, 0, 0, 0, 0, 0, 1, 10'd0, 4'd0, 5'd0,  5'd0);
        vt[9]  = mk(4004, 0, 0, 0, 0, 0, 1, 10'd0, 4'd0, 5'd0,  5'd0);
        vt[10] = mk(4005, 0, 0, 0, 0, 0, 1, 10'd1, 4'd0, 5'd0,  5'd0);
        vt[11] = mk(4006, 0, 1, 0, 0, 0, 1, 10'd0, 4'd0, 5'd0,  5'd0);
        vt[12] = mk(8005, 0, 1, 0, 0, 0, 1, 10'd0, 4'd9, 5'd19, 5'd19);
        vt[13] = mk(8006, 0, 0, 0, 0, 1, 1, 10'd0, 4'd0, 5'd0,  5'd0);

        reset = 1'b0; run = 1'b0; frame_tick = 1'b0; dir = 2'b00;
        s_reset = 1'b0; s_run = 1'b0; s_tick = 1'b0; s_dir = 2'b00;
        step();
        step();
        check("reset_outputs", 32'(pack_main()), 32'd0);
        check("reset_dir_ovr", 32'({dir_out, overrun}), 32'd0);

        reset = 1'b1; run = 1'b1;
        step();
        step();
        check("armed_busy", 32'(busy), 32'd0);

        run_frame("f1", 1'b1, 10'b0000000001, 2'b00, 2'b00, -1, -1, 1'b1);
        run_frame("f2", 1'b0, 10'd0, 2'b11, 2'b01, -1, -1, 1'b0);
        run_frame("f3", 1'b0, 10'd0, 2'b01, 2'b01, 5000, -1, 1'b0);
        run_frame("f4", 1'b0, 10'd0, 2'b01, 2'b10, -1, -1, 1'b0);
        run_frame("f5", 1'b1, 10'b0000000010, 2'b10, 2'b10, -1, -1, 1'b0);

        // Reset mid-DRAW at cycle 6000 of a frame.
        dir = 2'b10;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int i = 2; i <= 6000; i++) step();
        check("pre_rst_draw_busy", 32'({draw_en, erase, busy, overrun}), 32'b1011);
        reset = 1'b0;
        step();
        check("mid_rst_outputs", 32'(pack_main()), 32'd0);
        check("mid_rst_dir_ovr", 32'({dir_out, overrun}), 32'd0);
        reset = 1'b1;
        ov_model = 1'b0;
        step();
        step();
        run_frame("post_rst", 1'b1, 10'b0000000001, 2'b00, 2'b00, -1, 100, 1'b0);

        begin
            int bad_idle;
            bad_idle = 0;
            step();
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (busy || draw_en || erase || overrun) bad_idle++;
                step();
            end
            check("idle_tick_ignored", 32'(bad_idle), 32'd0);
        end

        // Small-tile instance: 41 frames, spawns on frames 1,5,..,41 walk slots 0..9 then 0.
        s_reset = 1'b0;
        step();
        step();
        s_reset = 1'b1; s_run = 1'b1;
        step();
        step();
        for (int f = 0; f < 41; f++) begin
            int c, done_c;
            logic [9:0] seen, exp_ld;
            seen = '0; done_c = 0; c = 1;
            s_tick = 1'b1;
            step();
            s_tick = 1'b0;
            while (done_c == 0 && c < 400) begin
                seen |= s_ld_blk;
                if (s_frame_done) done_c = c;
                step();
                c++;
            end
            exp_ld = (f % 4 == 0) ? (10'd1 << ((f / 4) % 10)) : 10'd0;
            check($sformatf("small_f%0d_ld", f + 1), 32'(seen), 32'(exp_ld));
            check($sformatf("small_f%0d_len", f + 1), 32'(done_c), (f % 4 == 0) ? 32'd326 : 32'd322);
        end
        check("small_overrun", 32'(s_overrun), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
